bus_transaction_controller: RTL and testbench
=============================================

BUS_TRANSACTION_CONTROLLER -- requirements
Module: bus_transaction_controller

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, bus address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, bus data width.
REQ-003 SHALL have parameter NUM_DEVICES, default 8, number of device enables.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, ACCESS cycles before timeout; legal range 1-65535.
REQ-005 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port req  input  1  master request valid.
REQ-008 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-009 SHALL have port req_phys_addr  input  ADDR_WIDTH  translated device-relative address.
REQ-010 SHALL have port req_device_en  input  NUM_DEVICES  one-hot device enable from the address translator.
REQ-011 SHALL have port req_wdata  input  DATA_WIDTH  write data.
REQ-012 SHALL have port req_ready  output  1  controller accepts a request this cycle.
REQ-013 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-014 SHALL have port resp_rdata  output  DATA_WIDTH  read data; valid with resp_valid.
REQ-015 SHALL have port resp_err  output  1  decode or timeout error; valid with resp_valid.
REQ-016 SHALL have port dev_addr, dev_wdata, dev_we  output  ADDR_WIDTH / DATA_WIDTH / 1  latched transaction fields.
REQ-017 SHALL have port dev_sel  output  NUM_DEVICES  latched one-hot select; all-zero outside ACCESS.
REQ-018 SHALL have port dev_strobe  output  1  high throughout ACCESS.
REQ-019 SHALL have port dev_ack  input  NUM_DEVICES  per-device completion.
REQ-020 SHALL have port dev_rdata  input  NUM_DEVICES*DATA_WIDTH  per-device read data, device i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-021 SHALL have port err_count  output  8  saturating error counter.

Function
REQ-022 SHALL implement the states IDLE, ACCESS and RESP.
REQ-023 SHALL drive req_ready=1 only in IDLE; a request is accepted when req && req_ready, and req in any other state SHALL be ignored (the master holds it).
REQ-024 SHALL, on acceptance, latch addr, we, wdata and device_en, and enter ACCESS if device_en is exactly one-hot, else enter RESP with the error flag set (decode error).
REQ-025 SHALL, in ACCESS, assert dev_strobe and dev_sel and complete when (dev_ack & latched sel) != 0; acks from unselected devices SHALL be ignored.
REQ-026 SHALL, on completion of a read, capture the selected device's dev_rdata slice into resp_rdata; writes SHALL return resp_rdata=0.
REQ-027 SHALL provide fixed latency: acceptance at edge N gives strobe in cycle N+1; an ack sampled at edge M gives resp_valid in cycle M+1; the minimum is resp_valid 2 cycles after acceptance.
REQ-028 SHALL, in RESP, hold resp_valid=1 for exactly one cycle (no back-pressure) and return to IDLE.
REQ-029 SHALL drive resp_rdata and resp_err to 0 whenever resp_valid=0.
REQ-030 SHALL increment err_count on each resp_err pulse and saturate it at 255.

Reset
REQ-031 SHALL, on rst assertion, immediately enter IDLE, including mid-ACCESS, abandoning the transaction without a response.
REQ-032 SHALL hold the following reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, dev_sel=0, dev_strobe=0, dev_we=0, dev_addr=0, dev_wdata=0, err_count=0, timeout counter=0.

Configuration
REQ-033 SHALL, with BUS_TIMEOUT_EN defined, count ACCESS cycles from 0, and if no valid ack arrives by the TIMEOUT_CYCLES-th ACCESS cycle, go to RESP with resp_err=1 and resp_rdata=0; an ack in that same cycle SHALL take priority over the timeout.
REQ-034 SHALL, without BUS_TIMEOUT_EN, have no counter logic, stay in ACCESS indefinitely until ack, and raise resp_err only on decode error.

Verification
REQ-035 The bench SHALL cover a read: device_en=8'b00000001, addr=0x10, device 0 acks in its first ACCESS cycle with rdata 0xBEEF -> resp_valid 2 cycles after acceptance, rdata=0xBEEF, err=0.
REQ-036 The bench SHALL cover a write: device_en=8'b00000100, wdata=0x1234, ack after 3 cycles -> dev_wdata=0x1234 and dev_we=1 during strobe, resp rdata=0, err=0.
REQ-037 The bench SHALL cover a decode error: device_en=0 and device_en=8'b00000011 -> no strobe, resp_err=1 one cycle later, err_count=2.
REQ-038 The bench SHALL cover timeout (macro on): TIMEOUT_CYCLES=4, no ack -> resp_err=1 after 4 ACCESS cycles; with the macro off, a late ack at 10 cycles still completes with err=0.
REQ-039 The bench SHALL cover a wrong-device ack: sel=device 2, ack on device 5 -> ignored, no response until device 2 acks.
REQ-040 The bench SHALL cover reset mid-ACCESS: rst pulse while strobe is high -> strobe and dev_sel drop immediately, no resp_valid, req_ready=1 after release.

Source files
------------

// File: rtl/bus_transaction_controller.sv
// Single-master bus transaction controller: IDLE -> ACCESS -> RESP with one-hot device select.
// Optional ACCESS timeout is enabled by defining BUS_TIMEOUT_EN.
module bus_transaction_controller #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 16,
    parameter int NUM_DEVICES    = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              req,
    input  logic                              req_we,
    input  logic [ADDR_WIDTH-1:0]             req_phys_addr,
    input  logic [NUM_DEVICES-1:0]            req_device_en,
    input  logic [DATA_WIDTH-1:0]             req_wdata,
    output logic                              req_ready,
    output logic                              resp_valid,
    output logic [DATA_WIDTH-1:0]             resp_rdata,
    output logic                              resp_err,
    output logic [ADDR_WIDTH-1:0]             dev_addr,
    output logic [DATA_WIDTH-1:0]             dev_wdata,
    output logic                              dev_we,
    output logic [NUM_DEVICES-1:0]            dev_sel,
    output logic                              dev_strobe,
    input  logic [NUM_DEVICES-1:0]            dev_ack,
    input  logic [NUM_DEVICES*DATA_WIDTH-1:0] dev_rdata,
    output logic [7:0]                        err_count
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range 1..65535");
    end

    state_t                 state, state_nxt;
    logic [NUM_DEVICES-1:0] sel_q;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_nxt, sel_rdata;
    logic                   err_q, err_nxt;
    logic                   accept, hit, en_onehot, to_hit;

    assign accept    = req && (state == IDLE);
    assign hit       = |(dev_ack & sel_q);
    assign en_onehot = $onehot(req_device_en);

`ifdef BUS_TIMEOUT_EN
    logic [15:0] to_cnt;

    // to_cnt holds the index of the current ACCESS cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  to_cnt <= '0;
        else if (accept)          to_cnt <= '0;
        else if (state == ACCESS) to_cnt <= to_cnt + 16'd1;
    end

    assign to_hit = (to_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    assign to_hit = 1'b0;
`endif

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_DEVICES; i++) begin
            if (sel_q[i]) sel_rdata = sel_rdata | dev_rdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // ack wins over a timeout landing in the same cycle
    always_comb begin
        state_nxt = state;
        rdata_nxt = rdata_q;
        err_nxt   = err_q;
        case (state)
            IDLE: begin
                if (req) begin
                    rdata_nxt = '0;
                    err_nxt   = !en_onehot;
                    state_nxt = en_onehot ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                if (hit) begin
                    state_nxt = RESP;
                    err_nxt   = 1'b0;
                    rdata_nxt = dev_we ? '0 : sel_rdata;
                end else if (to_hit) begin
                    state_nxt = RESP;
                    err_nxt   = 1'b1;
                    rdata_nxt = '0;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            sel_q     <= '0;
            dev_addr  <= '0;
            dev_wdata <= '0;
            dev_we    <= 1'b0;
            err_count <= '0;
        end else begin
            state   <= state_nxt;
            rdata_q <= rdata_nxt;
            err_q   <= err_nxt;
            if (accept) begin
                sel_q     <= req_device_en;
                dev_addr  <= req_phys_addr;
                dev_wdata <= req_wdata;
                dev_we    <= req_we;
            end
            if (state == RESP && err_q && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_rdata = resp_valid ? rdata_q : '0;
    assign resp_err   = resp_valid && err_q;
    assign dev_strobe = (state == ACCESS);
    assign dev_sel    = dev_strobe ? sel_q : '0;

endmodule

// File: tb/tb_bus_transaction_controller.sv
// Bench for bus_transaction_controller: directed table, randomized transactions vs. a latency model,
// and a reset-during-ACCESS sequence. Expectations follow BUS_TIMEOUT_EN when it is defined.
module tb_bus_transaction_controller;

`ifdef BUS_TIMEOUT_EN
    localparam bit TO_ON = 1'b1;
`else
    localparam bit TO_ON = 1'b0;
`endif
    localparam int TO = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req = 1'b0, req_we = 1'b0;
    logic [31:0]  req_phys_addr = '0;
    logic [7:0]   req_device_en = '0;
    logic [15:0]  req_wdata = '0;
    logic         req_ready, resp_valid, resp_err, dev_we, dev_strobe;
    logic [15:0]  resp_rdata, dev_wdata;
    logic [31:0]  dev_addr;
    logic [7:0]   dev_sel, err_count;
    logic [7:0]   dev_ack = '0;
    logic [15:0]  rd [8];
    logic [127:0] dev_rdata;

    always #5 clk = ~clk;

    always_comb begin
        dev_rdata = '0;
        for (int i = 0; i < 8; i++) dev_rdata[i*16 +: 16] = rd[i];
    end

    bus_transaction_controller #(
        .ADDR_WIDTH(32), .DATA_WIDTH(16), .NUM_DEVICES(8), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_phys_addr(req_phys_addr),
        .req_device_en(req_device_en), .req_wdata(req_wdata), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dev_we(dev_we), .dev_sel(dev_sel),
        .dev_strobe(dev_strobe), .dev_ack(dev_ack), .dev_rdata(dev_rdata), .err_count(err_count)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [7:0]  en;
        logic [15:0] wdata;
        int          delay;      // ACCESS cycle index in which the selected device acks
        int          wrong;      // device acking early (unselected), -1 for none
        logic [15:0] rdv;
        int          exp_lat;    // edges from acceptance to resp_valid
        logic        exp_err;
        logic [15:0] exp_rdata;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   model_ec = 0;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [7:0] en,
                                input logic [15:0] wdata, input int delay, input int wrong,
                                input logic [15:0] rdv, input int lat, input logic err,
                                input logic [15:0] rdata);
        vec_t v;
        v.we = we; v.addr = addr; v.en = en; v.wdata = wdata; v.delay = delay; v.wrong = wrong;
        v.rdv = rdv; v.exp_lat = lat; v.exp_err = err; v.exp_rdata = rdata;
        return v;
    endfunction

    // Reference: decode error answers next cycle, ack in ACCESS cycle d answers d+2 after
    // acceptance, and with the timeout on nothing waits past TO ACCESS cycles.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        if (!$onehot(v.en)) begin
            r.exp_lat = 1; r.exp_err = 1'b1; r.exp_rdata = '0;
        end else if (TO_ON && v.delay >= TO) begin
            r.exp_lat = TO + 1; r.exp_err = 1'b1; r.exp_rdata = '0;
        end else begin
            r.exp_lat = v.delay + 2; r.exp_err = 1'b0; r.exp_rdata = v.we ? 16'h0 : v.rdv;
        end
        return r;
    endfunction

    task automatic do_reset();
        rst = 1'b1; req = 1'b0; dev_ack = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_ec = 0;
        @(posedge clk); #1;
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int c = 1;
        bit got = 1'b0;
        bit oh = $onehot(v.en);
        for (int i = 0; i < 8; i++) rd[i] = 16'($urandom);
        for (int i = 0; i < 8; i++) if (v.en[i]) rd[i] = v.rdv;
        req = 1'b1; req_we = v.we; req_phys_addr = v.addr; req_device_en = v.en; req_wdata = v.wdata;
        chk({tag, ".ready"}, 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req = 1'b0; req_we = ~v.we; req_phys_addr = $urandom;
        req_device_en = 8'($urandom); req_wdata = 16'($urandom);
        while (!got && c <= 40) begin
            if (c == 1) begin
                chk({tag, ".strobe"}, 64'(dev_strobe), 64'(oh));
                if (oh) begin
                    chk({tag, ".sel"}, 64'(dev_sel), 64'(v.en));
                    chk({tag, ".fields"}, {dev_we, dev_addr, dev_wdata}, {v.we, v.addr, v.wdata});
                end
            end
            if (resp_valid) begin
                got = 1'b1;
                chk({tag, ".lat"}, 64'(c), 64'(v.exp_lat));
                chk({tag, ".err"}, 64'(resp_err), 64'(v.exp_err));
                chk({tag, ".rdata"}, 64'(resp_rdata), 64'(v.exp_rdata));
            end else begin
                chk({tag, ".quiet"}, {resp_err, resp_rdata}, '0);
                if (c - 1 == v.delay)                      dev_ack = v.en;
                else if (v.wrong >= 0 && c - 1 < v.delay) dev_ack = 8'(1 << v.wrong);
                else                                       dev_ack = '0;
                @(posedge clk); #1;
                c++;
            end
        end
        dev_ack = '0;
        if (!got) begin
            chk({tag, ".no_response"}, 64'(c), 64'(v.exp_lat));
            do_reset();
        end else begin
            if (v.exp_err && model_ec < 255) model_ec++;
            @(posedge clk); #1;
            chk({tag, ".one_pulse"}, 64'(resp_valid), 64'd0);
            chk({tag, ".err_count"}, 64'(err_count), 64'(model_ec));
        end
    endtask

    initial begin
        vec_t v;
        bit   seen;
        for (int i = 0; i < 8; i++) rd[i] = '0;

        tbl[0] = mk(0, 32'h10, 8'h01, 16'h0000, 0, -1, 16'hBEEF, 2, 0, 16'hBEEF);
        tbl[1] = mk(1, 32'h24, 8'h04, 16'h1234, 3, -1, 16'hFFFF, 5, 0, 16'h0000);
        tbl[2] = mk(0, 32'h30, 8'h00, 16'h0000, 0, -1, 16'h1111, 1, 1, 16'h0000);
        tbl[3] = mk(1, 32'h40, 8'h03, 16'h5555, 0, -1, 16'h2222, 1, 1, 16'h0000);
        tbl[4] = mk(0, 32'h50, 8'h04, 16'h0000, 2,  5, 16'h5A5A, 4, 0, 16'h5A5A);
        tbl[5] = TO_ON ? mk(0, 32'h60, 8'h10, 16'h0, 10, -1, 16'hC0DE, 5, 1, 16'h0)
                       : mk(0, 32'h60, 8'h10, 16'h0, 10, -1, 16'hC0DE, 12, 0, 16'hC0DE);
        tbl[6] = mk(0, 32'h70, 8'h20, 16'h0000, 3, -1, 16'h7777, 5, 0, 16'h7777);
        tbl[7] = TO_ON ? mk(1, 32'h80, 8'h40, 16'h9999, 1000, -1, 16'h0, 5, 1, 16'h0)
                       : mk(0, 32'h80, 8'h80, 16'h0000, 1, -1, 16'h8181, 3, 0, 16'h8181);

        #1;
        chk("rst.async", {req_ready, resp_valid, resp_err, resp_rdata, dev_sel, dev_strobe, dev_we},
            {1'b1, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0});
        chk("rst.fields", {dev_addr, dev_wdata, err_count}, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst.idle", {req_ready, resp_valid, dev_strobe}, {1'b1, 1'b0, 1'b0});

        for (int i = 0; i < 8; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        for (int n = 0; n < 60; n++) begin
            v.we    = 1'($urandom_range(0, 1));
            v.addr  = $urandom;
            v.wdata = 16'($urandom);
            v.en    = ($urandom_range(0, 9) < 8) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
            v.delay = $urandom_range(0, 7);
            v.wrong = $urandom_range(0, 1) ? int'($urandom_range(0, 7)) : -1;
            if (v.wrong >= 0 && v.en[v.wrong]) v.wrong = -1;
            v.rdv   = 16'($urandom);
            run_txn(model(v), $sformatf("rnd%0d", n));
        end

        // reset while strobe is high
        req = 1'b1; req_we = 1'b0; req_device_en = 8'h02; req_phys_addr = 32'hAB;
        @(posedge clk); #1;
        req = 1'b0;
        chk("rstmid.strobe_before", {dev_strobe, dev_sel}, {1'b1, 8'h02});
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rstmid.drop", {dev_strobe, dev_sel}, {1'b0, 8'h00});
        @(posedge clk); #1;
        rst = 1'b0;
        model_ec = 0;
        chk("rstmid.ready", 64'(req_ready), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (resp_valid || dev_strobe) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk("rstmid.no_resp", 64'(seen), 64'd0);
        chk("rstmid.err_count", 64'(err_count), 64'(model_ec));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
